// File: rtl/deserializer.sv
// deserializer: reassembles MSB-first serial frames into 16-bit MSB-aligned words with a bit count.
module deserializer #(
  parameter int MIN_BITS = 3
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic        ser_data_i,
  input  logic        ser_data_val_i,
  output logic [15:0] deser_data_o,
  output logic [3:0]  deser_data_mod_o,
  output logic        deser_data_val_o,
  output logic        busy_o,
  output logic        drop_o
);
  logic [15:0] shreg_q, shreg_d, data_q, data_d, wr;
  logic [4:0]  cnt_q, cnt_d, len;
  logic [3:0]  mod_q, mod_d;
  logic        val_q, val_d, drop_q, drop_d;
  logic        end_a, end_b, done, ok;
  always_comb begin
    wr = (cnt_q == 5'd0) ? 16'd0 : shreg_q;
    wr[4'd15 - cnt_q[3:0]] = ser_data_i;
    end_a = (cnt_q != 5'd0) && !ser_data_val_i;
    end_b = ser_data_val_i && (cnt_q == 5'd15);
    done = end_a || end_b;
    len = end_b ? 5'd16 : cnt_q;
    ok = len >= 5'(MIN_BITS);
    shreg_d = ser_data_val_i ? wr : shreg_q;
    // the 16th bit closes the frame on the same edge, so the next valid bit starts fresh
    cnt_d = (end_b || !ser_data_val_i) ? 5'd0 : cnt_q + 5'd1;
    data_d = (done && ok) ? (end_b ? wr : shreg_q) : data_q;
    mod_d = (done && ok) ? len[3:0] : mod_q;
    val_d = done && ok;
    drop_d = done && !ok;
  end
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      shreg_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      mod_q <= '0;
      val_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      mod_q <= mod_d;
      val_q <= val_d;
      drop_q <= drop_d;
    end
  end
  assign deser_data_o = data_q;
  assign deser_data_mod_o = mod_q;
  assign deser_data_val_o = val_q;
  assign drop_o = drop_q;
  assign busy_o = cnt_q != 5'd0;
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed and random frames checked against a bit-queue model of the receiver.
module tb_deserializer;
  localparam int MIN_BITS = 3;
  logic        clk = 1'b0;
  logic        arst_n_i = 1'b0;
  logic        ser_data_i = 1'b0;
  logic        ser_data_val_i = 1'b0;
  logic [15:0] deser_data_o;
  logic [3:0]  deser_data_mod_o;
  logic        deser_data_val_o, busy_o, drop_o;
  int checks = 0;
  int errors = 0;
  logic        q[$];
  logic [15:0] e_data = '0;
  logic [3:0]  e_mod = '0;
  logic        e_val = 1'b0, e_drop = 1'b0;

  deserializer #(.MIN_BITS(MIN_BITS)) dut (
    .clk_i(clk), .arst_n_i(arst_n_i), .ser_data_i(ser_data_i), .ser_data_val_i(ser_data_val_i),
    .deser_data_o(deser_data_o), .deser_data_mod_o(deser_data_mod_o),
    .deser_data_val_o(deser_data_val_o), .busy_o(busy_o), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("data", deser_data_o, e_data);
    chk("mod", 16'(deser_data_mod_o), 16'(e_mod));
    chk("val", 16'(deser_data_val_o), 16'(e_val));
    chk("drop", 16'(drop_o), 16'(e_drop));
    chk("busy", 16'(busy_o), 16'(q.size() != 0));
  endtask

  task automatic emit();
    logic [15:0] w;
    if (q.size() >= MIN_BITS) begin
      w = '0;
      foreach (q[i]) w[15-i] = q[i];
      e_data = w;
      e_mod = 4'(q.size() % 16);
      e_val = 1'b1;
    end else e_drop = 1'b1;
    q.delete();
  endtask

  task automatic model(input logic v, input logic b);
    e_val = 1'b0;
    e_drop = 1'b0;
    if (v) begin
      q.push_back(b);
      if (q.size() == 16) emit();
    end else if (q.size() != 0) emit();
  endtask

  task automatic step(input logic v, input logic b);
    ser_data_val_i = v;
    ser_data_i = b;
    @(posedge clk);
    model(v, b);
    #1 check_all();
  endtask

  task automatic send(input logic [31:0] w, input int n, input int gap);
    for (int i = 0; i < n; i++) step(1'b1, w[n-1-i]);
    for (int i = 0; i < gap; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    #12 check_all();
    arst_n_i = 1'b1;
    send(32'hA5C3, 16, 2);
    send(32'b10110, 5, 2);
    send(32'b10, 2, 2);
    send(32'hFFFFA, 20, 2);
    send(32'h7F, 7, 0);
    #2 arst_n_i = 1'b0;
    q.delete();
    e_data = '0; e_mod = '0; e_val = 1'b0; e_drop = 1'b0;
    #1 check_all();
    #2 arst_n_i = 1'b1;
    step(1'b0, 1'b0);
    send(32'hF, 4, 2);
    send(32'b101, 3, 1);
    send(32'hC3, 8, 1);
    send(32'h5AA5, 15, 2);
    for (int f = 0; f < 60; f++)
      send($urandom, int'($urandom_range(1, 20)), int'($urandom_range(1, 3)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
